adder_arbiter: RTL and testbench

//  Shares one registered 3-bit add/subtract datapath between two requesters.

---
 rtl/adder_arbiter.sv | 133 +++++++++++++
 tb/tb_adder_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter that lends one registered 3-bit
// add/subtract datapath to two requesters. It holds the operands on the adder
// for HOLD_CYCLES cycles, captures the settled result and returns it on a
// tagged response port with a valid/ready handshake.
module adder_arbiter #(
    parameter int HOLD_CYCLES = 6,
    parameter int CW          = 3
) (
    input  logic       clk,
    input  logic       rst,
    // requester 0
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [2:0] req0_a,
    input  logic [2:0] req0_b,
    input  logic       req0_sub,
    // requester 1
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [2:0] req1_a,
    input  logic [2:0] req1_b,
    input  logic       req1_sub,
    // shared adder
    output logic       add_cm1,
    output logic [2:0] add_a,
    output logic [2:0] add_b,
    input  logic [3:0] add_data,
    input  logic       add_ov,
    // tagged response
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [3:0] rsp_data,
    output logic       rsp_ov,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RSP  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          rr_ptr;
    logic [CW-1:0] cnt;
    logic          grant0;
    logic          grant1;
    logic          accept;
    logic          cnt_done;

    // Grant selection: a lone requester always wins; on contention rr_ptr
    // decides. grant1 is derived from ~grant0 so the two can never overlap.
    always_comb begin
        grant0     = req0_valid & (~req1_valid | ~rr_ptr);
        grant1     = req1_valid & ~grant0;
        req0_ready = (state == IDLE) & grant0;
        req1_ready = (state == IDLE) & grant1;
        accept     = req0_ready | req1_ready;
        cnt_done   = (cnt == '0);
    end

    assign busy = (state != IDLE);

    // Next-state logic: accept -> hold operands -> present response -> idle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)    state_next = BUSY;
            BUSY:    if (cnt_done)  state_next = RSP;
            RSP:     if (rsp_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // State register; reset abandons any op in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath registers: operands load only on accept, the result is
    // captured once the hold count expires, and the round-robin pointer
    // moves away from the requester just served when its response is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            add_a     <= '0;
            add_b     <= '0;
            add_cm1   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_ov    <= 1'b0;
            rr_ptr    <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        add_a   <= req1_ready ? req1_a   : req0_a;
                        add_b   <= req1_ready ? req1_b   : req0_b;
                        add_cm1 <= req1_ready ? req1_sub : req0_sub;
                        rsp_id  <= req1_ready;
                        cnt     <= CW'(HOLD_CYCLES - 1);
                    end
                end
                BUSY: begin
                    if (!cnt_done) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        rsp_data  <= add_data;
                        rsp_ov    <= add_ov;
                        rsp_valid <= 1'b1;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rr_ptr    <= ~rsp_id;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed scoreboard bench for adder_arbiter. A default
// build drives a two-stage registered adder model; a HOLD_CYCLES=1 build
// drives a combinational adder model.
`timescale 1ns/1ps
module tb_adder_arbiter;

    localparam int HOLD = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req0_sub;
    logic [2:0] req0_a, req0_b;
    logic       req1_valid, req1_ready, req1_sub;
    logic [2:0] req1_a, req1_b;
    logic       add_cm1, add_ov;
    logic [2:0] add_a, add_b;
    logic [3:0] add_data;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_ov, busy;
    logic [3:0] rsp_data;

    // HOLD_CYCLES=1 instance
    logic       h_req0_valid, h_req0_ready, h_req0_sub;
    logic [2:0] h_req0_a, h_req0_b;
    logic       h_req1_ready;
    logic       h_add_cm1, h_add_ov;
    logic [2:0] h_add_a, h_add_b;
    logic [3:0] h_add_data;
    logic       h_rsp_valid, h_rsp_ready, h_rsp_id, h_rsp_ov, h_busy;
    logic [3:0] h_rsp_data;

    typedef struct packed {
        logic       id;
        logic [3:0] data;
        logic       ov;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;
    int   stray    = 0;

    always #5 clk = ~clk;

    adder_arbiter #(.HOLD_CYCLES(HOLD), .CW(3)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
        .req0_b(req0_b), .req0_sub(req0_sub),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
        .req1_b(req1_b), .req1_sub(req1_sub),
        .add_cm1(add_cm1), .add_a(add_a), .add_b(add_b),
        .add_data(add_data), .add_ov(add_ov),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_ov(rsp_ov), .busy(busy)
    );

    adder_arbiter #(.HOLD_CYCLES(1), .CW(1)) dut_h1 (
        .clk(clk), .rst(rst),
        .req0_valid(h_req0_valid), .req0_ready(h_req0_ready), .req0_a(h_req0_a),
        .req0_b(h_req0_b), .req0_sub(h_req0_sub),
        .req1_valid(1'b0), .req1_ready(h_req1_ready), .req1_a(3'b000),
        .req1_b(3'b000), .req1_sub(1'b0),
        .add_cm1(h_add_cm1), .add_a(h_add_a), .add_b(h_add_b),
        .add_data(h_add_data), .add_ov(h_add_ov),
        .rsp_valid(h_rsp_valid), .rsp_ready(h_rsp_ready), .rsp_id(h_rsp_id),
        .rsp_data(h_rsp_data), .rsp_ov(h_rsp_ov), .busy(h_busy)
    );

    // Reference arithmetic: returns {ov, sign-extended 3-bit result}.
    function automatic logic [4:0] add_model(input logic [2:0] a, input logic [2:0] b,
                                             input logic sub);
        logic signed [3:0] sa, sb, r;
        sa = {a[2], a};
        sb = {b[2], b};
        r  = sub ? (sb - sa) : (sa + sb);
        return {r[3] ^ r[2], r[2], r[2:0]};
    endfunction

    // Two-stage registered adder for the default build.
    logic [4:0] pipe;
    always @(posedge clk) begin
        pipe              <= add_model(add_a, add_b, add_cm1);
        {add_ov, add_data} <= pipe;
    end

    // Combinational adder for the HOLD_CYCLES=1 build.
    assign {h_add_ov, h_add_data} = add_model(h_add_a, h_add_b, h_add_cm1);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one request just after a negedge, check the grant, log the
    // expected response and return at the negedge after the accept edge.
    task automatic issue(input logic id, input logic [2:0] a, input logic [2:0] b,
                         input logic sub);
        exp_t       e;
        logic [4:0] r;
        if (id) begin
            req1_a = a; req1_b = b; req1_sub = sub; req1_valid = 1'b1;
        end else begin
            req0_a = a; req0_b = b; req0_sub = sub; req0_valid = 1'b1;
        end
        #1;
        check("grant", {req1_ready, req0_ready}, id ? 32'd2 : 32'd1);
        r      = add_model(a, b, sub);
        e.id   = id;
        e.data = r[3:0];
        e.ov   = r[4];
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("add_ops", {add_cm1, add_a, add_b}, {sub, a, b});
    endtask

    // Count negedges until rsp_valid, bounded; also count readys seen while busy.
    task automatic wait_rsp(input int exp_lat);
        int lat;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
            if (!rsp_valid && (req0_ready || req1_ready)) stray++;
        end
        check("latency", lat, exp_lat);
    endtask

    // Compare the presented response to the scoreboard head, then handshake.
    task automatic take_rsp();
        exp_t e;
        if (sb_q.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
            return;
        end
        e = sb_q.pop_front();
        check("rsp", {rsp_valid, rsp_id, rsp_data, rsp_ov}, {1'b1, e.id, e.data, e.ov});
        $display("rsp id=%0d data=%b ov=%b", rsp_id, rsp_data, rsp_ov);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_done", {rsp_valid, busy, rsp_data, rsp_ov}, {1'b0, 1'b0, e.data, e.ov});
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t        e;
        logic [2:0]  ra, rb;
        logic        rs;
        logic [31:0] snap;
        int          changed, seen, w;

        rst = 1'b1;
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_sub = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_sub = 0;
        rsp_ready = 0;
        h_req0_valid = 0; h_req0_a = 0; h_req0_b = 0; h_req0_sub = 0; h_rsp_ready = 0;

        // Reset state
        @(negedge clk); #1;
        check("reset_outs", {req0_ready, req1_ready, add_cm1, add_a, add_b, rsp_valid,
                             rsp_id, rsp_data, rsp_ov, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single add on requester 0
        issue(1'b0, 3'd1, 3'd2, 1'b0);
        wait_rsp(HOLD);
        check("single_data", {rsp_id, rsp_data, rsp_ov}, {1'b0, 4'b0011, 1'b0});
        take_rsp();

        // Subtract on requester 1: B-A = -1
        issue(1'b1, 3'd2, 3'd1, 1'b1);
        wait_rsp(HOLD);
        check("sub_data", {rsp_id, rsp_data, rsp_ov}, {1'b1, 4'b1111, 1'b0});
        take_rsp();

        // Overflow corners
        issue(1'b0, 3'b011, 3'b011, 1'b0);
        wait_rsp(HOLD);
        take_rsp();
        issue(1'b1, 3'b001, 3'b100, 1'b1);
        wait_rsp(HOLD);
        take_rsp();

        // Contention from reset: grants must alternate 0,1,0,1
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        req0_a = 3'($urandom); req0_b = 3'($urandom); req0_sub = 1'($urandom);
        req1_a = 3'($urandom); req1_b = 3'($urandom); req1_sub = 1'($urandom);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            w = 0;
            while (!(req0_ready || req1_ready) && w < 20) begin
                @(negedge clk); #1;
                w++;
            end
            check("one_hot", {31'd0, req0_ready & req1_ready}, 32'd0);
            check("rr_order", {30'd0, req1_ready, req0_ready}, (k % 2) ? 32'd2 : 32'd1);
            if (req1_ready) begin
                ra = req1_a; rb = req1_b; rs = req1_sub; e.id = 1'b1;
            end else begin
                ra = req0_a; rb = req0_b; rs = req0_sub; e.id = 1'b0;
            end
            {e.ov, e.data} = add_model(ra, rb, rs);
            sb_q.push_back(e);
            @(posedge clk);
            @(negedge clk);
            if (e.id) begin
                req1_a = 3'($urandom); req1_b = 3'($urandom); req1_sub = 1'($urandom);
            end else begin
                req0_a = 3'($urandom); req0_b = 3'($urandom); req0_sub = 1'($urandom);
            end
            wait_rsp(HOLD);
            take_rsp();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("no_ready_busy", stray, 32'd0);

        // Backpressure: 10 cycles in RSP with rsp_ready low
        @(negedge clk);
        issue(1'b0, 3'b101, 3'b011, 1'b1);
        wait_rsp(HOLD);
        snap = {17'd0, rsp_valid, rsp_id, rsp_data, rsp_ov, add_cm1, add_a, add_b};
        req0_valid = 1'b1; req0_a = 3'd7; req0_b = 3'd6; req0_sub = 1'b0;
        req1_valid = 1'b1; req1_a = 3'd5; req1_b = 3'd4; req1_sub = 1'b1;
        changed = 0;
        stray   = 0;
        repeat (10) begin
            @(negedge clk); #1;
            if ({17'd0, rsp_valid, rsp_id, rsp_data, rsp_ov, add_cm1, add_a, add_b} != snap)
                changed++;
            if (req0_ready || req1_ready) stray++;
        end
        check("bp_stable", changed, 32'd0);
        check("bp_no_ready", stray, 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        take_rsp();

        // Reset while BUSY with cnt=2
        issue(1'b1, 3'b011, 3'b010, 1'b0);
        repeat (3) @(negedge clk);
        check("busy_before_rst", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_async", {req0_ready, req1_ready, add_cm1, add_a, add_b, rsp_valid,
                            rsp_id, rsp_data, rsp_ov, busy}, 32'd0);
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("no_rsp_after_rst", seen, 32'd0);

        // HOLD_CYCLES=1 build: -1 + -2 = -3
        h_req0_a = 3'b111; h_req0_b = 3'b110; h_req0_sub = 1'b0; h_req0_valid = 1'b1;
        #1;
        check("h1_ready", {31'd0, h_req0_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        h_req0_valid = 1'b0;
        check("h1_not_yet", {31'd0, h_rsp_valid}, 32'd0);
        @(negedge clk);
        check("h1_rsp", {h_rsp_valid, h_rsp_id, h_rsp_ov, h_rsp_data}, {1'b1, 1'b0, 1'b0, 4'b1101});
        $display("h1 rsp id=%0d data=%b ov=%b", h_rsp_id, h_rsp_data, h_rsp_ov);
        h_rsp_ready = 1'b1;
        @(negedge clk);
        h_rsp_ready = 1'b0;
        check("h1_done", {30'd0, h_rsp_valid, h_busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
